csel_add_arbiter: RTL and testbench

Shared, multi-cycle M-bit adder that serves two requesters over one N-bit carry-select slice. It arbitrates round-robin between two operand ports and sequences the addition N bits per cycle, least-significant chunk first, rippling the carry between chunks. It returns a registered {Cout, Sum} result with a valid/ready handshake. It sits wherever two datapath clients need occasional wide adds and area matters more than latency.

---
 rtl/csel_add_arbiter.sv | 96 +++++++++
 tb/tb_csel_add_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/csel_add_arbiter.sv
// csel_add_arbiter: round-robin shared M-bit adder, N bits per cycle through a carry-select slice
//   clk, rst_n            clock, asynchronous active-low reset
//   reqX_valid/reqX_ready operand handshake per requester (X = 0, 1); ready only in IDLE
//   reqX_A, reqX_B        M-bit operands of requester X
//   res_valid/res_ready   result handshake; Sum/Cout/res_id held stable while res_valid
//   res_id                requester that owns the presented result
//   Sum, Cout             {Cout, Sum} = A + B
module csel_add_arbiter #(
    parameter int M = 32,
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [M-1:0] req0_A,
    input  logic [M-1:0] req0_B,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [M-1:0] req1_A,
    input  logic [M-1:0] req1_B,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic [M-1:0] Sum,
    output logic         Cout
);
    localparam int C  = M / N;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t         r_state;
    logic [M-1:0]   r_a, r_b, r_acc;
    logic           r_carry, r_ptr, r_id;
    logic [KW-1:0]  r_k;
    logic           w_gnt0, w_gnt1;
    logic [N-1:0]   w_ca, w_cb;
    logic [N:0]     w_sum0, w_sum1, w_sel;
    // ptr names the winner only when both requesters contend
    assign w_gnt0     = req0_valid && (!req1_valid || !r_ptr);
    assign w_gnt1     = req1_valid && (!req0_valid || r_ptr);
    // rst_n gating keeps both readies low while reset is held
    assign req0_ready = rst_n && (r_state == IDLE) && w_gnt0;
    assign req1_ready = rst_n && (r_state == IDLE) && w_gnt1;
    // carry-select slice: both carry-in variants precomputed, stored carry picks one
    assign w_ca   = r_a[N*int'(r_k) +: N];
    assign w_cb   = r_b[N*int'(r_k) +: N];
    assign w_sum0 = {1'b0, w_ca} + {1'b0, w_cb};
    assign w_sum1 = w_sum0 + (N+1)'(1);
    assign w_sel  = r_carry ? w_sum1 : w_sum0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_carry   <= 1'b0;
            r_ptr     <= 1'b0;
            r_id      <= 1'b0;
            r_k       <= '0;
            res_valid <= 1'b0;
            res_id    <= 1'b0;
            Sum       <= '0;
            Cout      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_gnt0 || w_gnt1) begin
                    r_a     <= w_gnt1 ? req1_A : req0_A;
                    r_b     <= w_gnt1 ? req1_B : req0_B;
                    r_id    <= w_gnt1;
                    r_carry <= 1'b0;
                    r_k     <= '0;
                    r_state <= CALC;
                end
                CALC: begin
                    r_acc[N*int'(r_k) +: N] <= w_sel[N-1:0];
                    r_carry <= w_sel[N];
                    r_k     <= r_k + 1'b1;
                    // last chunk goes straight to Sum; lower chunks are already in r_acc
                    if (r_k == KW'(C-1)) begin
                        Sum       <= {w_sel[N-1:0], r_acc[M-N-1:0]};
                        Cout      <= w_sel[N];
                        res_id    <= r_id;
                        res_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    r_ptr     <= ~res_id;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csel_add_arbiter.sv
// tb_csel_add_arbiter: scoreboard bench for csel_add_arbiter with a reference grant/latency model
module tb_csel_add_arbiter;
    localparam int M = 32;
    localparam int N = 4;
    localparam int C = M / N;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, res_ready;
    logic         req0_ready, req1_ready, res_valid, res_id, Cout;
    logic [M-1:0] req0_A, req0_B, req1_A, req1_B, Sum;
    typedef struct {
        logic       id;
        logic [M:0] r;
    } exp_t;
    exp_t sb[$];
    int   served[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic m_busy = 1'b0;
    logic m_ptr  = 1'b0;
    int   m_cnt  = 0;
    bit   acc0 = 1'b0;
    bit   acc1 = 1'b0;
    csel_add_arbiter #(.M(M), .N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_A(req1_A), .req1_B(req1_B),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .Sum(Sum), .Cout(Cout)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    // reference model: sampled on negedge, between input updates and the next active edge
    always @(negedge clk) begin : mon
        logic e0, e1, erv;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_ptr  = 1'b0;
            m_cnt  = 0;
            acc0   = 1'b0;
            acc1   = 1'b0;
            sb.delete();
        end else begin
            if (m_busy) m_cnt++;
            erv = m_busy && (m_cnt >= C + 1);
            e0  = !m_busy && req0_valid && (!req1_valid || !m_ptr);
            e1  = !m_busy && req1_valid && (!req0_valid || m_ptr);
            chk("res_valid", 64'(res_valid), 64'(erv));
            chk("req0_ready", 64'(req0_ready), 64'(e0));
            chk("req1_ready", 64'(req1_ready), 64'(e1));
            if (erv && sb.size() > 0) begin
                chk("sum", 64'(Sum), 64'(sb[0].r[M-1:0]));
                chk("cout", 64'(Cout), 64'(sb[0].r[M]));
                chk("res_id", 64'(res_id), 64'(sb[0].id));
            end
            if (e0 || e1) begin
                sb.push_back('{id: e1, r: e1 ? {1'b0, req1_A} + {1'b0, req1_B}
                                              : {1'b0, req0_A} + {1'b0, req0_B}});
                m_busy = 1'b1;
                m_cnt  = 0;
                if (e1) acc1 = 1'b1; else acc0 = 1'b1;
            end else if (erv && res_ready && sb.size() > 0) begin
                served.push_back(int'(sb[0].id));
                m_ptr  = !sb[0].id;
                m_busy = 1'b0;
                void'(sb.pop_front());
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask
    task automatic wait_rv(output int lat);
        lat = 0;
        while (!res_valid && lat < 50) begin
            tick();
            lat++;
        end
        if (!res_valid) chk("rv_timeout", 64'(0), 64'(1));
    endtask
    task automatic drain();
        int n;
        n = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b1;
        while (m_busy && n < 50) begin
            tick();
            n++;
        end
        if (m_busy) chk("drain_timeout", 64'(0), 64'(1));
        tick();
    endtask
    initial begin
        int lat, n;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_A = '0; req0_B = '0; req1_A = '0; req1_B = '0;
        res_ready = 1'b0;
        repeat (3) tick();
        chk("rst_sum", 64'(Sum), 64'(0));
        chk("rst_cout", 64'(Cout), 64'(0));
        chk("rst_id", 64'(res_id), 64'(0));
        chk("rst_rv", 64'(res_valid), 64'(0));
        chk("rst_rdy0", 64'(req0_ready), 64'(0));
        chk("rst_rdy1", 64'(req1_ready), 64'(0));
        req0_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        // single request through the full carry chain
        res_ready = 1'b1;
        req0_A = 32'hFFFF_FFFF; req0_B = 32'h0000_0001; req0_valid = 1'b1;
        #1 chk("t1_ready", 64'(req0_ready), 64'(1));
        tick();
        req0_valid = 1'b0;
        wait_rv(lat);
        chk("t1_lat", 64'(lat), 64'(C));
        chk("t1_sum", 64'(Sum), 64'(0));
        chk("t1_cout", 64'(Cout), 64'(1));
        chk("t1_id", 64'(res_id), 64'(0));
        drain();
        // contention from reset: strict alternation starting with requester 0
        do_reset();
        served.delete();
        req0_A = 32'h0000_000F; req0_B = 32'h0000_0001;
        req1_A = 32'h8000_0000; req1_B = 32'h8000_0000;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        n = 0;
        while (served.size() < 4 && n < 200) begin
            tick();
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("cont_count", 64'(served.size()), 64'(4));
        for (int i = 0; i < 4 && i < served.size(); i++) chk("cont_order", 64'(served[i]), 64'(i % 2));
        drain();
        // backpressure with both valids held high throughout
        res_ready = 1'b0;
        req0_A = 32'hAAAA_5555; req0_B = 32'h5555_AAAA;
        req1_A = 32'h0000_0003; req1_B = 32'h0000_0004;
        req0_valid = 1'b1; req1_valid = 1'b1;
        wait_rv(lat);
        repeat (5) begin
            tick();
            chk("bp_rv", 64'(res_valid), 64'(1));
            chk("bp_sum", 64'(Sum), 64'(32'hFFFF_FFFF));
            chk("bp_cout", 64'(Cout), 64'(0));
            chk("bp_id", 64'(res_id), 64'(0));
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        tick();
        chk("bp_taken", 64'(res_valid), 64'(0));
        drain();
        // requester 1 raises valid only while a result is pending, then withdraws
        res_ready = 1'b0;
        req0_A = 32'h0000_1000; req0_B = 32'h0000_0234; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        wait_rv(lat);
        req1_valid = 1'b1;
        tick();
        req1_valid = 1'b0;
        chk("wd_sum", 64'(Sum), 64'(32'h0000_1234));
        tick();
        res_ready = 1'b1;
        repeat (12) tick();
        chk("wd_rv", 64'(res_valid), 64'(0));
        drain();
        // asynchronous reset in the third CALC cycle
        req0_A = 32'hFFFF_0000; req0_B = 32'h0001_FFFF; req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mr_sum", 64'(Sum), 64'(0));
        chk("mr_cout", 64'(Cout), 64'(0));
        chk("mr_id", 64'(res_id), 64'(0));
        chk("mr_rv", 64'(res_valid), 64'(0));
        tick();
        rst_n = 1'b1;
        req1_A = 32'h1234_5678; req1_B = 32'h1111_1111; req1_valid = 1'b1;
        #1 chk("mr_ready1", 64'(req1_ready), 64'(1));
        tick();
        req1_valid = 1'b0;
        wait_rv(lat);
        chk("mr_lat", 64'(lat), 64'(C));
        chk("mr_sum2", 64'(Sum), 64'(32'h2345_6789));
        chk("mr_cout2", 64'(Cout), 64'(0));
        chk("mr_id2", 64'(res_id), 64'(1));
        drain();
        // random regression: random ports, operands, withdrawals and consumer stalls
        served.delete();
        n = 0;
        while (served.size() < 1000 && n < 40000) begin
            if (acc0) begin
                acc0 = 1'b0;
                req0_valid = 1'b0;
            end else if (!req0_valid && $urandom_range(0, 3) == 0) begin
                req0_A = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
                req0_B = $urandom;
                req0_valid = 1'b1;
            end else if (req0_valid && $urandom_range(0, 19) == 0) req0_valid = 1'b0;
            if (acc1) begin
                acc1 = 1'b0;
                req1_valid = 1'b0;
            end else if (!req1_valid && $urandom_range(0, 3) == 0) begin
                req1_A = $urandom;
                req1_B = ($urandom_range(0, 7) == 0) ? '1 : $urandom;
                req1_valid = 1'b1;
            end else if (req1_valid && $urandom_range(0, 19) == 0) req1_valid = 1'b0;
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
            n++;
        end
        chk("rand_count", 64'(served.size() >= 1000), 64'(1));
        drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
